// File: rtl/ctrl_word_pkg.sv
// Shared definitions for the 16-bit packed control-word format.
// Used by both the control-word packer and the unpacker.
package ctrl_word_pkg;

    localparam int WORD_W     = 16;

    // Bit positions inside the packed word
    localparam int RSVD_BIT   = 15;
    localparam int A_MSB      = 14;
    localparam int A_LSB      = 12;
    localparam int B_MSB      = 11;
    localparam int B_LSB      = 8;
    localparam int CIN_BIT    = 7;
    localparam int C_MSB      = 6;
    localparam int C_LSB      = 4;
    localparam int REC_MSB    = 3;
    localparam int REC_LSB    = 2;
    localparam int PC_EN_BIT  = 1;
    localparam int REG_EN_BIT = 0;

    // Output stage state
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // Decoded fields; covers every bit of the word except the reserved bit
    typedef struct packed {
        logic [2:0] a;
        logic [3:0] b;
        logic       cin;
        logic [2:0] c;
        logic [1:0] rec;
        logic       pc_en;
        logic       reg_en;
    } ctrl_fields_t;

    // Split the non-reserved part of a packed word into named fields
    function automatic ctrl_fields_t unpack_word(input logic [RSVD_BIT-1:0] w);
        ctrl_fields_t f;
        f.a      = w[A_MSB:A_LSB];
        f.b      = w[B_MSB:B_LSB];
        f.cin    = w[CIN_BIT];
        f.c      = w[C_MSB:C_LSB];
        f.rec    = w[REC_MSB:REC_LSB];
        f.pc_en  = w[PC_EN_BIT];
        f.reg_en = w[REG_EN_BIT];
        return f;
    endfunction

endpackage

// File: rtl/ctrl_word_unpack_if.sv
// Handshake bus of the control-word unpacker: packed words in, decoded
// fields and strobes out. master = word source / field consumer side,
// slave = the unpacker itself.
interface ctrl_word_unpack_if;
    import ctrl_word_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_word;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        field_a;
    logic [3:0]        field_b;
    logic              cin;
    logic [2:0]        field_c;
    logic [1:0]        rec;
    logic              pc_en_stb;
    logic              reg_en_stb;

    modport master (
        output in_valid, in_word, out_ready,
        input  in_ready, out_valid, field_a, field_b, cin, field_c, rec,
               pc_en_stb, reg_en_stb
    );

    modport slave (
        input  in_valid, in_word, out_ready,
        output in_ready, out_valid, field_a, field_b, cin, field_c, rec,
               pc_en_stb, reg_en_stb
    );

endinterface

// File: rtl/ctrl_word_fifo.sv
// Small synchronous FIFO between the input handshake and the output stage.
// Pointers carry one extra wrap bit so full/empty come from an MSB compare.
// DEPTH must be a power of two, >= 2. No bypass: a pushed entry is visible
// at the head only after the edge that wrote it.
module ctrl_word_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Advance pointers on push/pop; flush drops every stored entry
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Write the tail entry
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; the pointers alone decide what is valid.
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                     (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/ctrl_word_unpack.sv
// Consumer end of the 16-bit packed control-word format. Buffers accepted
// words in a FIFO, drops words with the reserved bit set (sticky err_rsvd),
// and presents registered fields plus single-cycle pc_en/reg_en strobes on
// the downstream handshake.
// Optional: define CTRL_WORD_UNPACK_ERRCNT_EN to add err_cnt[7:0], a
// saturating count of dropped reserved-bit words.
module ctrl_word_unpack
    import ctrl_word_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    ctrl_word_unpack_if.slave    bus,
    output logic                 err_rsvd
`ifdef CTRL_WORD_UNPACK_ERRCNT_EN
    ,
    output logic [7:0]           err_cnt
`endif
);

    out_state_e   state;
    logic         out_valid_q;
    ctrl_fields_t fields_q;
    ctrl_fields_t head;
    logic         fifo_full;
    logic         fifo_empty;
    logic         accept;
    logic         rsvd_hit;
    logic         push;
    logic         load;

    // Ready is held low during reset and otherwise reflects the pre-edge full flag
    assign bus.in_ready = reset & ~fifo_full;
    assign accept       = bus.in_valid & bus.in_ready;
    assign rsvd_hit     = accept & bus.in_word[RSVD_BIT];
    assign push         = accept & ~bus.in_word[RSVD_BIT] & ~flush;

    // Take the head when the output stage is empty or is being consumed now
    assign load = ~flush & ~fifo_empty & ((state == EMPTY) | bus.out_ready);

    ctrl_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH - 1)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (flush),
        .push    (push),
        .pop     (load),
        .wr_data (unpack_word(bus.in_word[RSVD_BIT-1:0])),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Output stage: load/reload field registers from the FIFO head
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            fields_q    <= '0;
        end else if (flush) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (load) begin
                        fields_q    <= head;
                        state       <= FULL;
                        out_valid_q <= 1'b1;
                    end
                end
                FULL: begin
                    if (bus.out_ready) begin
                        if (load) begin
                            fields_q <= head;
                        end else begin
                            state       <= EMPTY;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= EMPTY;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid  = out_valid_q;
    assign bus.field_a    = fields_q.a;
    assign bus.field_b    = fields_q.b;
    assign bus.cin        = fields_q.cin;
    assign bus.field_c    = fields_q.c;
    assign bus.rec        = fields_q.rec;
    assign bus.pc_en_stb  = fields_q.pc_en  & out_valid_q & bus.out_ready;
    assign bus.reg_en_stb = fields_q.reg_en & out_valid_q & bus.out_ready;

    // Sticky reserved-bit error; only reset clears it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        err_rsvd <= 1'b0;
        else if (rsvd_hit) err_rsvd <= 1'b1;
    end

`ifdef CTRL_WORD_UNPACK_ERRCNT_EN
    // Saturating count of dropped reserved-bit words; only reset clears it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                             err_cnt <= 8'h00;
        else if (rsvd_hit && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
    end
`endif

endmodule

// File: tb/tb_ctrl_word_unpack.sv
// Directed testbench for ctrl_word_unpack. Inputs change 1 time unit after
// the rising edge; outputs are sampled in the same window.
`timescale 1ns/1ps
module tb_ctrl_word_unpack;
    import ctrl_word_pkg::*;

    logic clk;
    logic reset;
    logic flush;
    logic err_rsvd;
`ifdef CTRL_WORD_UNPACK_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    int checks;
    int errors;

    ctrl_word_unpack_if bus ();

    ctrl_word_unpack #(
        .DEPTH (2),
        .WIDTH (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .bus      (bus),
        .err_rsvd (err_rsvd)
`ifdef CTRL_WORD_UNPACK_ERRCNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_word   = 16'h0000;
        bus.out_ready = 1'b0;

        // Reset state
        #3;
        check("rst_in_ready",  32'(bus.in_ready),  0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_err_rsvd",  32'(err_rsvd),      0);
        check("rst_field_a",   32'(bus.field_a),   0);
        check("rst_reg_en",    32'(bus.reg_en_stb), 0);
        step();
        step();
        reset = 1'b1;
        #1;
        check("rel_in_ready",  32'(bus.in_ready),  1);

        // Single word 5A9F, latency of two edges
        bus.in_valid  = 1'b1;
        bus.in_word   = 16'h5A9F;
        bus.out_ready = 1'b1;
        step();
        bus.in_valid  = 1'b0;
        check("w1_lat_valid",  32'(bus.out_valid), 0);
        step();
        check("w1_valid",      32'(bus.out_valid), 1);
        check("w1_a",          32'(bus.field_a),   5);
        check("w1_b",          32'(bus.field_b),   32'hA);
        check("w1_cin",        32'(bus.cin),       1);
        check("w1_c",          32'(bus.field_c),   1);
        check("w1_rec",        32'(bus.rec),       3);
        check("w1_pc_stb",     32'(bus.pc_en_stb), 1);
        check("w1_reg_stb",    32'(bus.reg_en_stb), 1);
        step();
        check("w1_done_valid", 32'(bus.out_valid), 0);
        check("w1_done_pc",    32'(bus.pc_en_stb), 0);
        check("w1_done_reg",   32'(bus.reg_en_stb), 0);

        // Reserved bit set: dropped, sticky error survives flush
        bus.in_valid = 1'b1;
        bus.in_word  = 16'h8000;
        step();
        bus.in_valid = 1'b0;
        check("rsvd_err",      32'(err_rsvd),      1);
        step();
        check("rsvd_no_valid", 32'(bus.out_valid), 0);
`ifdef CTRL_WORD_UNPACK_ERRCNT_EN
        check("rsvd_cnt",      32'(err_cnt),       1);
`endif
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("rsvd_err_flush", 32'(err_rsvd),     1);
`ifdef CTRL_WORD_UNPACK_ERRCNT_EN
        check("rsvd_cnt_flush", 32'(err_cnt),      1);
`endif

        // Backpressure: fill output stage and FIFO, then drain
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_word   = 16'h1000;
        step();
        bus.in_word   = 16'h2000;
        step();
        check("bp_valid",      32'(bus.out_valid), 1);
        check("bp_a1",         32'(bus.field_a),   1);
        check("bp_ready_2",    32'(bus.in_ready),  1);
        bus.in_word   = 16'h3000;
        step();
        bus.in_valid  = 1'b0;
        check("bp_full",       32'(bus.in_ready),  0);
        check("bp_a1_hold",    32'(bus.field_a),   1);
        step();
        check("bp_a1_hold2",   32'(bus.field_a),   1);
        check("bp_valid_hold", 32'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        #1;
        check("bp_pc_zero",    32'(bus.pc_en_stb), 0);
        step();
        check("bp_a2",         32'(bus.field_a),   2);
        check("bp_ready_free", 32'(bus.in_ready),  1);
        step();
        check("bp_a3",         32'(bus.field_a),   3);
        check("bp_a3_valid",   32'(bus.out_valid), 1);
        step();
        check("bp_drained",    32'(bus.out_valid), 0);

        // Back-to-back stream of 0001
        bus.in_valid = 1'b1;
        bus.in_word  = 16'h0001;
        step();
        check("st_lat_reg",    32'(bus.reg_en_stb), 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("st_valid",  32'(bus.out_valid),  1);
            check("st_reg",    32'(bus.reg_en_stb), 1);
            check("st_pc",     32'(bus.pc_en_stb),  0);
            check("st_ready",  32'(bus.in_ready),   1);
        end
        bus.in_valid = 1'b0;
        step();
        step();
        check("st_drained",    32'(bus.out_valid), 0);

        // Flush with a concurrent accept of 7FFF
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_word   = 16'h1000;
        step();
        bus.in_word   = 16'h2000;
        step();
        check("fl_pre_valid",  32'(bus.out_valid), 1);
        bus.in_word   = 16'h7FFF;
        flush         = 1'b1;
        step();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        check("fl_valid",      32'(bus.out_valid), 0);
        check("fl_ready",      32'(bus.in_ready),  1);
        bus.out_ready = 1'b1;
        step();
        check("fl_no_word1",   32'(bus.out_valid), 0);
        step();
        check("fl_no_word2",   32'(bus.out_valid), 0);

        // Asynchronous reset mid-stream
        bus.in_valid = 1'b1;
        bus.in_word  = 16'h0053;
        step();
        step();
        check("ar_pre_valid",  32'(bus.out_valid),  1);
        check("ar_pre_c",      32'(bus.field_c),    5);
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid",      32'(bus.out_valid),  0);
        check("ar_c",          32'(bus.field_c),    0);
        check("ar_reg",        32'(bus.reg_en_stb), 0);
        check("ar_pc",         32'(bus.pc_en_stb),  0);
        check("ar_in_ready",   32'(bus.in_ready),   0);
        check("ar_err",        32'(err_rsvd),       0);
        bus.in_valid = 1'b0;
        step();
        reset = 1'b1;
        #1;
        check("ar_rel_ready",  32'(bus.in_ready),   1);
        step();
        check("ar_rel_valid",  32'(bus.out_valid),  0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
